// File: rtl/rram_frame_packer_if.sv
// Stream bundle for rram_frame_packer: readout words in, framed UART bytes out.
interface rram_frame_packer_if #(parameter int DATA_W = 64);
  logic [DATA_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic [7:0]        tx_byte;
  logic              tx_byte_valid;
  logic              tx_byte_ready;

  modport master (output word_in, word_valid, tx_byte_ready,
                  input  word_ready, tx_byte, tx_byte_valid);
  modport slave  (input  word_in, word_valid, tx_byte_ready,
                  output word_ready, tx_byte, tx_byte_valid);
endinterface

// File: rtl/rram_frame_packer.sv
// Buffers RingRAM readout words and emits each as sync, data bytes MSB first, XOR checksum.
// Define FRAME_SEQ_EN to insert an 8-bit frame sequence byte after the sync byte.
//
// state | meaning
// IDLE  | waiting for a word; pops FIFO head into the shift register
// HDR   | presenting SYNC_BYTE
// SEQ   | presenting frame sequence number (FRAME_SEQ_EN only)
// DATA  | presenting shift register top byte, NB bytes
// CSUM  | presenting XOR checksum of everything after the sync byte
module rram_frame_packer #(
  parameter int         DATA_W     = 64,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  rram_frame_packer_if.slave  bus,
  output logic                busy,
  output logic                overflow,
  output logic [15:0]         frame_count
);
  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM
`ifdef FRAME_SEQ_EN
    , S_SEQ
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty, push, pop, xfer;
  logic [DATA_W-1:0] shift;
  logic [IW-1:0]     idx;
  logic [7:0]        chk;
`ifdef FRAME_SEQ_EN
  logic [7:0]        seq;
`endif

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Admission looks only at full, so a same-cycle pop never frees a slot early.
  assign bus.word_ready = !full;
  assign push = bus.word_valid && !full;
  assign pop  = (state == S_IDLE) && !empty;
  assign xfer = (state != S_IDLE) && bus.tx_byte_ready;
  assign busy = (state != S_IDLE) || !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    bus.tx_byte       = 8'h00;
    bus.tx_byte_valid = 1'b0;
    case (state)
      S_IDLE: if (!empty) state_nxt = S_HDR;
      S_HDR: begin
        bus.tx_byte       = SYNC_BYTE;
        bus.tx_byte_valid = 1'b1;
`ifdef FRAME_SEQ_EN
        if (bus.tx_byte_ready) state_nxt = S_SEQ;
`else
        if (bus.tx_byte_ready) state_nxt = S_DATA;
`endif
      end
`ifdef FRAME_SEQ_EN
      S_SEQ: begin
        bus.tx_byte       = seq;
        bus.tx_byte_valid = 1'b1;
        if (bus.tx_byte_ready) state_nxt = S_DATA;
      end
`endif
      S_DATA: begin
        bus.tx_byte       = shift[DATA_W-1 -: 8];
        bus.tx_byte_valid = 1'b1;
        if (bus.tx_byte_ready && idx == LAST_IDX) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        bus.tx_byte       = chk;
        bus.tx_byte_valid = 1'b1;
        if (bus.tx_byte_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.word_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      frame_count <= 16'd0;
      shift       <= '0;
      idx         <= '0;
      chk         <= 8'h00;
`ifdef FRAME_SEQ_EN
      seq         <= 8'h00;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (bus.word_valid && full) overflow <= 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        shift  <= mem[rd_ptr[AW-1:0]];
        idx    <= '0;
        chk    <= 8'h00;
      end
      if (xfer) begin
        case (state)
`ifdef FRAME_SEQ_EN
          S_SEQ: chk <= chk ^ seq;
`endif
          S_DATA: begin
            chk   <= chk ^ shift[DATA_W-1 -: 8];
            shift <= shift << 8;
            idx   <= idx + IW'(1);
          end
          S_CSUM: begin
            frame_count <= frame_count + 16'd1;
`ifdef FRAME_SEQ_EN
            seq         <= seq + 8'd1;
`endif
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rram_frame_packer.sv
// Directed bench for rram_frame_packer: framing, stalls, FIFO full/overflow, reset, sequence byte.
module tb_rram_frame_packer;
  localparam int DATA_W = 64;
  localparam int NB     = DATA_W / 8;
`ifdef FRAME_SEQ_EN
  localparam int FL = NB + 3;
  localparam logic [7:0] T1 [FL] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67,
                                     8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00};
`else
  localparam int FL = NB + 2;
  // XOR of the eight data bytes of 0123_4567_89AB_CDEF cancels to 00
  localparam logic [7:0] T1 [FL] = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67,
                                     8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00};
`endif
  localparam logic [63:0] W3 [5] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                                     64'h99AA_BBCC_DDEE_FF00, 64'h0F1E_2D3C_4B5A_6978,
                                     64'hFEDC_BA98_7654_3210};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, overflow;
  logic [15:0] frame_count;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_seq = 8'h00;
  logic [7:0]  exp_b [FL];

  rram_frame_packer_if #(.DATA_W(DATA_W)) bus ();

  rram_frame_packer #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .busy(busy), .overflow(overflow), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] w);
    bus.word_in    = w;
    bus.word_valid = 1'b1;
    step();
    bus.word_valid = 1'b0;
  endtask

  task automatic load_frame(input logic [63:0] w);
    logic [7:0] c;
    int off;
    exp_b[0] = 8'hA5;
`ifdef FRAME_SEQ_EN
    exp_b[1] = exp_seq;
    c = exp_seq;
    off = 2;
`else
    c = 8'h00;
    off = 1;
`endif
    for (int j = 0; j < NB; j++) begin
      exp_b[off+j] = w[63-8*j -: 8];
      c = c ^ w[63-8*j -: 8];
    end
    exp_b[FL-1] = c;
  endtask

  // Starts in the cycle the frame is (or is about to be) presented; ends one cycle after the checksum transfer.
  task automatic rx_frame(input bit rnd);
    int  waited;
    bit  done;
    for (int k = 0; k < FL; k++) begin
      waited = 0;
      done   = 1'b0;
      while (!done) begin
        bus.tx_byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.tx_byte_valid && bus.tx_byte_ready) begin
          check_val("byte", 64'(bus.tx_byte), 64'(exp_b[k]));
          done = 1'b1;
        end else if (bus.tx_byte_valid) begin
          check_val("stall_hold", 64'(bus.tx_byte), 64'(exp_b[k]));
        end
        step();
        waited++;
        if (!done && waited > 100) begin
          check_val("rx_timeout", 64'(waited), 64'd0);
          bus.tx_byte_ready = 1'b1;
          return;
        end
      end
    end
    exp_seq = exp_seq + 8'd1;
    bus.tx_byte_ready = 1'b1;
  endtask

  initial begin
    bus.word_in       = '0;
    bus.word_valid    = 1'b0;
    bus.tx_byte_ready = 1'b0;
    #2;
    check_val("rst_valid", 64'(bus.tx_byte_valid), 64'd0);
    check_val("rst_byte",  64'(bus.tx_byte),       64'd0);
    check_val("rst_busy",  64'(busy),              64'd0);
    check_val("rst_ovf",   64'(overflow),          64'd0);
    check_val("rst_fc",    64'(frame_count),       64'd0);
    check_val("rst_wrdy",  64'(bus.word_ready),    64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // basic frame and first-byte latency
    bus.tx_byte_ready = 1'b1;
    push_word(64'h0123_4567_89AB_CDEF);
    check_val("lat_n1_valid", 64'(bus.tx_byte_valid), 64'd0);
    check_val("lat_n1_busy",  64'(busy),              64'd1);
    step();
    check_val("lat_n2_valid", 64'(bus.tx_byte_valid), 64'd1);
    check_val("lat_n2_sync",  64'(bus.tx_byte),       64'hA5);
    for (int k = 0; k < FL; k++) exp_b[k] = T1[k];
    rx_frame(1'b0);
    check_val("t1_fc",   64'(frame_count), 64'd1);
    check_val("t1_busy", 64'(busy),        64'd0);

    // same word under random backpressure
    push_word(64'h0123_4567_89AB_CDEF);
    load_frame(64'h0123_4567_89AB_CDEF);
    rx_frame(1'b1);
    check_val("t2_fc", 64'(frame_count), 64'd2);

    // fill with the transmitter stalled
    bus.tx_byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val("t3_wrdy_fill", 64'(bus.word_ready), 64'd1);
      push_word(W3[i]);
    end
    check_val("t3_wrdy_full", 64'(bus.word_ready), 64'd0);
    check_val("t3_ovf_pre",   64'(overflow),       64'd0);
    push_word(64'hDEAD_BEEF_DEAD_BEEF);
    check_val("t3_ovf_set",   64'(overflow),       64'd1);
    check_val("t3_valid_hold", 64'(bus.tx_byte_valid), 64'd1);
    check_val("t3_sync_hold",  64'(bus.tx_byte),       64'hA5);

    load_frame(W3[0]);
    rx_frame(1'b0);
    // IDLE with a full FIFO: the pop this cycle must not admit the offered word
    check_val("t4_wrdy", 64'(bus.word_ready), 64'd0);
    check_val("t4_busy", 64'(busy),           64'd1);
    push_word(64'hBAD0_BAD0_BAD0_BAD0);
    check_val("t4_wrdy_after", 64'(bus.word_ready), 64'd1);
    for (int i = 1; i < 5; i++) begin
      load_frame(W3[i]);
      rx_frame(1'b1);
    end
    check_val("t4_fc",    64'(frame_count), 64'd7);
    check_val("t4_busy0", 64'(busy),        64'd0);
    step();
    check_val("t4_no_extra", 64'(bus.tx_byte_valid), 64'd0);
    check_val("t4_ovf_sticky", 64'(overflow), 64'd1);

    // asynchronous reset mid-frame
    bus.tx_byte_ready = 1'b1;
    load_frame(64'h0011_2233_4455_6677);
    push_word(64'h0011_2233_4455_6677);
    step();
    repeat (4) step();
    check_val("t5_mid_valid", 64'(bus.tx_byte_valid), 64'd1);
    check_val("t5_mid_byte",  64'(bus.tx_byte),       64'(exp_b[4]));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t5_valid", 64'(bus.tx_byte_valid), 64'd0);
    check_val("t5_byte",  64'(bus.tx_byte),       64'd0);
    check_val("t5_busy",  64'(busy),              64'd0);
    check_val("t5_ovf",   64'(overflow),          64'd0);
    check_val("t5_fc",    64'(frame_count),       64'd0);
    check_val("t5_wrdy",  64'(bus.word_ready),    64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_seq = 8'h00;
    step();
    push_word(64'hA1B2_C3D4_E5F6_0718);
    load_frame(64'hA1B2_C3D4_E5F6_0718);
    rx_frame(1'b0);
    check_val("t5_fc_restart", 64'(frame_count), 64'd1);

`ifdef FRAME_SEQ_EN
    // sequence byte wraps after 256 frames
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_seq = 8'h00;
    step();
    for (int i = 0; i < 257; i++) begin
      push_word(64'h0102_0304_0506_0700 ^ 64'(i));
      load_frame(64'h0102_0304_0506_0700 ^ 64'(i));
      rx_frame(1'b0);
    end
    check_val("t6_fc",  64'(frame_count), 64'd257);
    check_val("t6_seq", 64'(exp_seq),     64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
